// File: rtl/debug_text_pkg.sv
// Shared text-dump definitions: dump FSM state encoding and nibble-to-ASCII conversion.
// Also used by the top-level debug display.
package debug_text_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEL   = 3'd1,
      S_LATCH = 3'd2,
      S_LABEL = 3'd3,
      S_DIGIT = 3'd4,
      S_NEXT  = 3'd5,
      S_FIN   = 3'd6
   } dump_state_t;

   localparam logic [7:0] CHAR_X     = 8'h78;
   localparam logic [7:0] CHAR_COLON = 8'h3A;
   localparam logic [7:0] CHAR_0     = 8'h30;

   // 'A' is 8'h41, so 8'h37 + 10 lands on it.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (CHAR_0 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

endpackage

// File: rtl/reg_hex_dumper_if.sv
// Control, register-file read port and text-buffer write port of the register hex dumper.
// The slave modport is the dumper; the master modport is its environment.
interface reg_hex_dumper_if #(
   parameter int WORD_SIZE = 32,
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = 13
);
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                 start;
   logic                 label_en;
   logic                 busy;
   logic                 done;
   logic [IDX_W-1:0]     reg_addr;
   logic [WORD_SIZE-1:0] reg_data;
   logic                 txt_we;
   logic [ADDR_W-1:0]    txt_addr;
   logic [31:0]          txt_data;
   logic                 txt_ready;

   modport slave (
      input  start, label_en, reg_data, txt_ready,
      output busy, done, reg_addr, txt_we, txt_addr, txt_data
   );

   modport master (
      output start, label_en, reg_data, txt_ready,
      input  busy, done, reg_addr, txt_we, txt_addr, txt_data
   );

endinterface

// File: rtl/hex_ascii_enc.sv
// Combinational 4-bit nibble to uppercase hex ASCII character.
module hex_ascii_enc
   import debug_text_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [7:0] o_ascii
);

   assign o_ascii = nibble_to_ascii(i_nib);

endmodule

// File: rtl/reg_hex_dumper.sv
// Walks the register file and writes each register as a row of hex characters into a text buffer.
// One character per cycle while the sink is ready; a stalled character is held until accepted.
module reg_hex_dumper
   import debug_text_pkg::*;
#(
   parameter int          WORD_SIZE = 32,
   parameter int          NUM_REGS  = 32,
   parameter int          TEXT_COLS = 80,
   parameter int          ADDR_W    = 13,
   parameter int          BASE_ROW  = 0,
   parameter logic [23:0] ATTR      = 24'hFFFFFF
) (
   input  logic           clk,
   input  logic           rst,
   reg_hex_dumper_if.slave bus
);

   localparam int NIB   = WORD_SIZE / 4;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int POS_W = $clog2(NIB + 5);

   dump_state_t          r_state;
   logic [IDX_W-1:0]     r_index;
   logic                 r_label;
   logic [WORD_SIZE-1:0] r_word;
   logic [POS_W-1:0]     r_pos;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_txt_we;
   logic [ADDR_W-1:0]    r_txt_addr;
   logic [31:0]          r_txt_data;

   logic [3:0]           w_nib;
   logic [7:0]           w_hex;
   logic [7:0]           w_idx8;
   logic [7:0]           w_label_chr;
   logic [ADDR_W-1:0]    w_row_addr;
   logic [POS_W-1:0]     w_row_len;
   logic                 w_last_idx;

   // The first digit of a row is encoded straight from reg_data in the LATCH cycle.
   always_comb begin
      w_nib       = (r_state == S_LATCH) ? bus.reg_data[WORD_SIZE-1 -: 4] : r_word[WORD_SIZE-1 -: 4];
      w_idx8      = 8'(r_index);
      w_row_addr  = ADDR_W'((BASE_ROW + int'(r_index)) * TEXT_COLS);
      w_row_len   = r_label ? POS_W'(NIB + 4) : POS_W'(NIB);
      w_last_idx  = (r_index == IDX_W'(NUM_REGS - 1));
      w_label_chr = CHAR_COLON;
      if (r_pos == POS_W'(1)) begin
         w_label_chr = CHAR_0 + (w_idx8 / 8'd10);
      end else if (r_pos == POS_W'(2)) begin
         w_label_chr = CHAR_0 + (w_idx8 % 8'd10);
      end
   end

   hex_ascii_enc u_hex_ascii_enc (
      .i_nib   (w_nib),
      .o_ascii (w_hex)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_label    <= 1'b0;
         r_word     <= '0;
         r_pos      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_txt_we   <= 1'b0;
         r_txt_addr <= '0;
         r_txt_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_label <= bus.label_en;
                  r_index <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SEL;
               end
            end
            S_SEL: r_state <= S_LATCH;
            S_LATCH: begin
               r_txt_we   <= 1'b1;
               r_txt_addr <= w_row_addr;
               r_pos      <= POS_W'(1);
               if (r_label) begin
                  r_word     <= bus.reg_data;
                  r_txt_data <= {CHAR_X, ATTR};
                  r_state    <= S_LABEL;
               end else begin
                  r_word     <= bus.reg_data << 4;
                  r_txt_data <= {w_hex, ATTR};
                  r_state    <= S_DIGIT;
               end
            end
            // r_pos is the row position of the next character to present.
            S_LABEL, S_DIGIT: begin
               if (bus.txt_ready) begin
                  if (r_pos == w_row_len) begin
                     r_txt_we <= 1'b0;
                     r_state  <= S_NEXT;
                  end else begin
                     r_txt_addr <= r_txt_addr + ADDR_W'(1);
                     r_pos      <= r_pos + POS_W'(1);
                     if (r_label && (r_pos < POS_W'(4))) begin
                        r_txt_data <= {w_label_chr, ATTR};
                        r_state    <= S_LABEL;
                     end else begin
                        r_txt_data <= {w_hex, ATTR};
                        r_word     <= r_word << 4;
                        r_state    <= S_DIGIT;
                     end
                  end
               end
            end
            S_NEXT: begin
               if (w_last_idx) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_index <= r_index + IDX_W'(1);
                  r_state <= S_SEL;
               end
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.reg_addr = r_index;
   assign bus.txt_we   = r_txt_we;
   assign bus.txt_addr = r_txt_addr;
   assign bus.txt_data = r_txt_data;

endmodule

// File: tb/tb_reg_hex_dumper.sv
// Directed bench: three dumper instances (4 regs, 8 regs, 4 regs at BASE_ROW 100) share stimulus.
module tb_reg_hex_dumper;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic start     = 1'b0;
   logic label_en  = 1'b0;
   logic txt_ready = 1'b1;
   bit   stall_en  = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_hex_dumper_if #(.WORD_SIZE(32), .NUM_REGS(4), .ADDR_W(13)) if_a ();
   reg_hex_dumper_if #(.WORD_SIZE(32), .NUM_REGS(8), .ADDR_W(13)) if_b ();
   reg_hex_dumper_if #(.WORD_SIZE(32), .NUM_REGS(4), .ADDR_W(13)) if_c ();

   reg_hex_dumper #(.WORD_SIZE(32), .NUM_REGS(4), .TEXT_COLS(80), .ADDR_W(13), .BASE_ROW(0), .ATTR(24'hFFFFFF))
      u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   reg_hex_dumper #(.WORD_SIZE(32), .NUM_REGS(8), .TEXT_COLS(80), .ADDR_W(13), .BASE_ROW(0), .ATTR(24'hFFFFFF))
      u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   reg_hex_dumper #(.WORD_SIZE(32), .NUM_REGS(4), .TEXT_COLS(80), .ADDR_W(13), .BASE_ROW(100), .ATTR(24'hFFFFFF))
      u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   assign if_a.start = start;     assign if_a.label_en = label_en;     assign if_a.txt_ready = txt_ready;
   assign if_b.start = start;     assign if_b.label_en = label_en;     assign if_b.txt_ready = txt_ready;
   assign if_c.start = start;     assign if_c.label_en = label_en;     assign if_c.txt_ready = txt_ready;

   // Register files with one cycle of read latency.
   always @(posedge clk) if_a.reg_data <= 32'hDEADBEEF + 32'(if_a.reg_addr);
   always @(posedge clk) if_b.reg_data <= (if_b.reg_addr == 3'd7) ? 32'h0000000A : 32'hDEADBEEF + 32'(if_b.reg_addr);
   always @(posedge clk) if_c.reg_data <= 32'hDEADBEEF + 32'(if_c.reg_addr);

   // Sink ready pattern 1,0,0,1 repeating when stalling is enabled.
   logic [3:0] pat = 4'b1001;
   int         ph  = 0;
   always @(posedge clk) begin
      #1;
      if (stall_en) begin
         txt_ready = pat[ph[1:0]];
         ph++;
      end else begin
         txt_ready = 1'b1;
      end
   end

   // Text-buffer models and write monitors.
   logic [7:0]  mem [3][8192];
   bit          seen_a [8192];
   int          wr [3];
   int          done_a, busy_cyc_a, dup_a, hold_err_a, attr_bad_b, first_addr_a;
   bit          clr = 1'b0;
   bit          prev_stall = 1'b0;
   logic [12:0] p_addr;
   logic [31:0] p_data;

   always @(negedge clk) begin
      if (clr) begin
         for (int k = 0; k < 3; k++) begin
            wr[k] = 0;
            for (int j = 0; j < 8192; j++) mem[k][j] = 8'h00;
         end
         for (int j = 0; j < 8192; j++) seen_a[j] = 1'b0;
         done_a = 0; busy_cyc_a = 0; dup_a = 0; hold_err_a = 0; attr_bad_b = 0; first_addr_a = -1;
         prev_stall = 1'b0;
      end else if (!rst) begin
         if (if_a.txt_we && txt_ready) begin
            if (wr[0] == 0) first_addr_a = int'(if_a.txt_addr);
            if (seen_a[if_a.txt_addr]) dup_a++;
            seen_a[if_a.txt_addr] = 1'b1;
            mem[0][if_a.txt_addr] = if_a.txt_data[31:24];
            wr[0]++;
         end
         if (if_b.txt_we && txt_ready) begin
            if (if_b.txt_data[23:0] != 24'hFFFFFF) attr_bad_b++;
            mem[1][if_b.txt_addr] = if_b.txt_data[31:24];
            wr[1]++;
         end
         if (if_c.txt_we && txt_ready) begin
            mem[2][if_c.txt_addr] = if_c.txt_data[31:24];
            wr[2]++;
         end
         if (if_a.done) done_a++;
         if (if_a.busy) busy_cyc_a++;
         if (prev_stall && !(if_a.txt_we && if_a.txt_addr == p_addr && if_a.txt_data == p_data)) hold_err_a++;
         prev_stall = if_a.txt_we && !txt_ready;
         p_addr     = if_a.txt_addr;
         p_data     = if_a.txt_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] get_str(input int inst, input int base, input int n);
      logic [127:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[119:0], mem[inst][(base + i) % 8192]};
      return r;
   endfunction

   task automatic clear_mon();
      clr = 1'b1;
      @(negedge clk);
      #1 clr = 1'b0;
   endtask

   task automatic pulse_start(input bit lab);
      @(posedge clk);
      #1 start = 1'b1;
      label_en = lab;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((if_a.busy || if_b.busy || if_c.busy) && n < budget);
      chk(tag, 128'(n < budget), 128'(1));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",     128'(if_a.busy),     128'(0));
      chk("rst_done",     128'(if_a.done),     128'(0));
      chk("rst_txt_we",   128'(if_a.txt_we),   128'(0));
      chk("rst_txt_addr", 128'(if_a.txt_addr), 128'(0));
      chk("rst_txt_data", 128'(if_a.txt_data), 128'(0));
      chk("rst_reg_addr", 128'(if_a.reg_addr), 128'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      clear_mon();

      // Plain dump, sink always ready.
      pulse_start(1'b0);
      wait_idle("t1_finish", 500);
      chk("t1_writes_a",  128'(wr[0]),      128'(32));
      chk("t1_row0_a",    get_str(0, 0, 8),   {64'h0, "DEADBEEF"});
      chk("t1_row3_a",    get_str(0, 240, 8), {64'h0, "DEADBEF2"});
      chk("t1_done_a",    128'(done_a),     128'(1));
      chk("t1_busy_cyc",  128'(busy_cyc_a), 128'(44));
      chk("t1_dup_a",     128'(dup_a),      128'(0));
      chk("t1_writes_b",  128'(wr[1]),      128'(64));
      chk("t1_row0_c",    get_str(2, 8000, 8), {64'h0, "DEADBEEF"});
      chk("t1_row3_wrap", get_str(2, 48, 8),   {64'h0, "DEADBEF2"});

      // Labelled dump.
      clear_mon();
      pulse_start(1'b1);
      wait_idle("t2_finish", 800);
      chk("t2_writes_a", 128'(wr[0]),         128'(48));
      chk("t2_row0_a",   get_str(0, 0, 12),   {32'h0, "x00:DEADBEEF"});
      chk("t2_row7_b",   get_str(1, 560, 12), {32'h0, "x07:0000000A"});
      chk("t2_attr_b",   128'(attr_bad_b),    128'(0));
      chk("t2_writes_b", 128'(wr[1]),         128'(96));

      // Sink stalls.
      clear_mon();
      stall_en = 1'b1;
      pulse_start(1'b0);
      wait_idle("t3_finish", 2000);
      stall_en = 1'b0;
      chk("t3_writes_a", 128'(wr[0]),        128'(32));
      chk("t3_dup_a",    128'(dup_a),        128'(0));
      chk("t3_hold_a",   128'(hold_err_a),   128'(0));
      chk("t3_row1_a",   get_str(0, 80, 8),  {64'h0, "DEADBEF0"});
      chk("t3_done_a",   128'(done_a),       128'(1));

      // Reset in the middle of a dump.
      clear_mon();
      pulse_start(1'b0);
      n = 0;
      while (wr[0] < 10 && n < 200) begin
         @(negedge clk);
         #1 n++;
      end
      chk("t4_reach10", 128'(n < 200), 128'(1));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t4_we_after_rst",   128'(if_a.txt_we), 128'(0));
      chk("t4_busy_after_rst", 128'(if_a.busy),   128'(0));
      chk("t4_writes_at_rst",  128'(wr[0]),       128'(10));
      @(posedge clk);
      #1 rst = 1'b0;
      clear_mon();
      pulse_start(1'b0);
      wait_idle("t4_finish", 500);
      chk("t4_first_addr", 128'(first_addr_a), 128'(0));
      chk("t4_row0_a",     get_str(0, 0, 8),   {64'h0, "DEADBEEF"});
      chk("t4_writes_a",   128'(wr[0]),        128'(32));

      // Start pulses while busy and in the FIN cycle are ignored.
      clear_mon();
      pulse_start(1'b0);
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!if_a.done && n < 200);
      chk("t5_fin_seen", 128'(if_a.done), 128'(1));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle("t5_finish", 800);
      chk("t5_busy_a",   128'(if_a.busy), 128'(0));
      chk("t5_done_a",   128'(done_a),    128'(1));
      chk("t5_writes_a", 128'(wr[0]),     128'(32));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
